// File: rtl/cache_refill_ctrl_if.sv
// Next-level memory read bus: one line request, then the line's beats in ascending order.
interface cache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 32
);
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  data_valid;
  logic [BEAT_WIDTH-1:0] data;

  modport master (output rd_valid, rd_addr, input rd_ready, data_valid, data);
  modport slave  (input rd_valid, rd_addr, output rd_ready, data_valid, data);
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill: invalidate the set, fetch a line beat by beat, commit data/tag and set valid.
// Optional macro REFILL_PERF_CNT_EN adds a saturating miss_count output.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 512,
  parameter int BEAT_WIDTH     = 32,
  parameter int BEATS_PER_LINE = 8,
  localparam int INDEX_WIDTH   = $clog2(DEPTH),
  localparam int OFFSET_WIDTH  = $clog2(BEATS_PER_LINE * BEAT_WIDTH / 8),
  localparam int TAG_WIDTH     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int LINE_WIDTH    = BEAT_WIDTH * BEATS_PER_LINE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   lookup_valid,
  input  logic [ADDR_WIDTH-1:0]  lookup_addr,
  input  logic                   lookup_hit,
  output logic                   stall,
  cache_refill_ctrl_if.master    mem,
  output logic                   line_wren,
  output logic [INDEX_WIDTH-1:0] line_waddr,
  output logic [LINE_WIDTH-1:0]  line_data,
  output logic [TAG_WIDTH-1:0]   tag_data,
  output logic                   state_wren,
  output logic [INDEX_WIDTH-1:0] state_waddr,
  output logic                   state_data,
  output logic                   refill_done
`ifdef REFILL_PERF_CNT_EN
  ,
  output logic [31:0]            miss_count
`endif
);

  localparam int CNT_W = $clog2(BEATS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, INVAL, REQ, FILL, COMMIT} state_t;

  state_t                state_reg, state_next;
  logic                  abort_reg, abort_next;
  logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  beat_we;
  logic                  miss;
  logic                  unused_offset;

  assign miss          = lookup_valid & ~lookup_hit & ~flush;
  assign unused_offset = ^addr_reg[OFFSET_WIDTH-1:0];

  assign mem.rd_addr = {addr_reg[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign line_waddr  = addr_reg[OFFSET_WIDTH +: INDEX_WIDTH];
  assign state_waddr = addr_reg[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag_data    = addr_reg[ADDR_WIDTH-1 -: TAG_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      abort_reg    <= 1'b0;
      beat_cnt_reg <= '0;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      abort_reg    <= abort_next;
      beat_cnt_reg <= beat_cnt_next;
      addr_reg     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    abort_next    = abort_reg;
    beat_cnt_next = beat_cnt_reg;
    addr_next     = addr_reg;
    beat_we       = 1'b0;
    mem.rd_valid  = 1'b0;
    line_wren     = 1'b0;
    state_wren    = 1'b0;
    state_data    = 1'b0;
    refill_done   = 1'b0;
    stall         = (state_reg != IDLE) | miss;
    case (state_reg)
      IDLE: begin
        if (miss) begin
          addr_next  = lookup_addr;
          state_next = INVAL;
        end
      end
      INVAL: begin
        state_wren = 1'b1;
        state_next = flush ? IDLE : REQ;
      end
      REQ: begin
        mem.rd_valid = 1'b1;
        if (flush) abort_next = 1'b1;
        if (mem.rd_ready) begin
          beat_cnt_next = '0;
          state_next    = FILL;
        end
      end
      FILL: begin
        if (flush) abort_next = 1'b1;
        if (mem.data_valid) begin
          // Aborted refills still consume every beat so the bus returns to idle cleanly.
          beat_we       = ~(abort_reg | flush);
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          if (beat_cnt_reg == LAST_BEAT) begin
            if (abort_reg | flush) begin
              abort_next = 1'b0;
              state_next = IDLE;
            end else begin
              state_next = COMMIT;
            end
          end
        end
      end
      COMMIT: begin
        line_wren   = 1'b1;
        state_wren  = 1'b1;
        state_data  = 1'b1;
        refill_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line buffer: one register per beat slot, beat 0 in the LSBs.
  for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_beat
    logic [BEAT_WIDTH-1:0] beat_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        beat_reg <= '0;
      end else if (beat_we && beat_cnt_reg == CNT_W'(gi)) begin
        beat_reg <= mem.data;
      end
    end
    assign line_data[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat_reg;
  end

`ifdef REFILL_PERF_CNT_EN
  logic [31:0] miss_count_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_reg <= '0;
    end else if (refill_done && miss_count_reg != 32'hFFFF_FFFF) begin
      miss_count_reg <= miss_count_reg + 32'd1;
    end
  end
  assign miss_count = miss_count_reg;
`endif

endmodule
